// File: rtl/capture_pkg.sv
// Shared types and constants for the capture RAM readout path.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    localparam int         DEF_ADDR_W = 18;
    localparam int         DEF_DATA_W = 8;
    localparam logic [7:0] HDR_SYNC   = 8'hA5;
    localparam int         HDR_LEN    = 4;

    // Header byte idx of a readout: sync, then length little-endian, zero-padded.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] len);
        case (idx)
            2'd0:    hdr_byte = HDR_SYNC;
            2'd1:    hdr_byte = len[7:0];
            2'd2:    hdr_byte = len[15:8];
            default: hdr_byte = len[23:16];
        endcase
    endfunction

endpackage

// File: rtl/capture_readout_if.sv
// RAM read port and outgoing byte stream of the capture readout block.
interface capture_readout_if #(
    parameter int ADDR_W = capture_pkg::DEF_ADDR_W,
    parameter int DATA_W = capture_pkg::DEF_DATA_W
);
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output ram_en, ram_addr, m_data, m_valid, input ram_din, m_ready);
    modport slave  (input ram_en, ram_addr, m_data, m_valid, output ram_din, m_ready);
endinterface

// File: rtl/readout_fifo2.sv
// Two-entry first-word-fall-through FIFO used as the readout prefetch buffer.
module readout_fifo2
    import capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic                   wr_ptr_reg, rd_ptr_reg;
    logic [1:0]             count_reg;
    logic                   do_wr, do_rd;
    logic [1:0][DATA_W-1:0] entry_data;

    assign do_rd = rd_en && (count_reg != 2'd0);
    // A write into a full FIFO lands in the head slot that this cycle's pop frees.
    assign do_wr = wr_en && ((count_reg != 2'd2) || do_rd);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (do_wr && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= wr_data;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_wr) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_rd) rd_ptr_reg <= ~rd_ptr_reg;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = entry_data[rd_ptr_reg];
    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign count   = count_reg;
endmodule

// File: rtl/capture_readout.sv
// Reads a programmed window out of the circular capture RAM and streams it as bytes.
// Define CAPTURE_READOUT_HEADER_EN to prefix every readout with a 4-beat header.
module capture_readout
    import capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    capture_readout_if.master bus
);
    localparam int CNT_W = ADDR_W + 2;
`ifdef CAPTURE_READOUT_HEADER_EN
    localparam int HDR_BEATS = HDR_LEN;
`else
    localparam int HDR_BEATS = 0;
`endif
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   remaining_reg, remaining_next;
    logic [CNT_W-1:0]  beats_reg, beats_next;
    logic              inflight_reg;
    logic              accept, fifo_pop, room;
    logic              hdr_active;
    logic [DATA_W-1:0] hdr_data, fifo_data;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;

    readout_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight_reg),
        .wr_data (bus.ram_din),
        .rd_en   (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef CAPTURE_READOUT_HEADER_EN
    logic [2:0]      hdr_left_reg;
    logic [ADDR_W:0] len_reg;

    assign hdr_active = (hdr_left_reg != 3'd0);
    assign hdr_data   = DATA_W'(hdr_byte(2'(HDR_LEN - int'(hdr_left_reg)), 24'(len_reg)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_left_reg <= 3'd0;
            len_reg      <= '0;
        end else if ((state_reg == IDLE) && start) begin
            hdr_left_reg <= 3'(HDR_LEN);
            len_reg      <= length;
        end else if (accept && hdr_active) begin
            hdr_left_reg <= hdr_left_reg - 3'd1;
        end
    end
`else
    assign hdr_active = 1'b0;
    assign hdr_data   = '0;
`endif

    assign bus.m_valid = hdr_active || !fifo_empty;
    assign bus.m_data  = hdr_active ? hdr_data : (fifo_empty ? '0 : fifo_data);
    assign accept      = bus.m_valid && bus.m_ready;
    assign fifo_pop    = accept && !hdr_active;
    // Occupancy is counted after this cycle's pop so a streaming sink sees no bubbles.
    assign room = fifo_full ? (fifo_pop && !inflight_reg)
                            : ((fifo_count == 2'd0) || fifo_pop || !inflight_reg);

    assign busy = (state_reg == READ) || (state_reg == DRAIN);
    assign done = (state_reg == FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            beats_reg     <= '0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            beats_reg     <= beats_next;
            inflight_reg  <= bus.ram_en;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        beats_next     = beats_reg;
        bus.ram_en     = 1'b0;
        bus.ram_addr   = addr_reg;
        if (accept) beats_next = beats_reg - CNT_ONE;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    beats_next = CNT_W'(length) + CNT_W'(HDR_BEATS);
                    state_next = ((length == '0) && (HDR_BEATS == 0)) ? FIN : READ;
                    // The first read goes out in the start cycle to meet first-beat latency.
                    if (length != '0) begin
                        bus.ram_en     = 1'b1;
                        bus.ram_addr   = start_addr;
                        addr_next      = start_addr + ADDR_ONE;
                        remaining_next = length - REM_ONE;
                    end else begin
                        remaining_next = '0;
                    end
                end
            end
            READ: begin
                if ((remaining_reg != '0) && room) begin
                    bus.ram_en     = 1'b1;
                    addr_next      = addr_reg + ADDR_ONE;
                    remaining_next = remaining_reg - REM_ONE;
                end
                if (remaining_reg == '0) state_next = DRAIN;
            end
            DRAIN:   state_next = DRAIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (busy && accept && (beats_reg == CNT_ONE)) state_next = FIN;
    end
endmodule

// File: tb/tb_capture_readout.sv
// Self-checking bench for capture_readout: a table of readouts scored against a RAM model.
`timescale 1ns/1ps
module tb_capture_readout;
    import capture_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef CAPTURE_READOUT_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    // FIN arrives this many cycles later when the header precedes the data.
    localparam int HDR_EXTRA = (HDR > 0) ? HDR - 1 : 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;

    capture_readout_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    capture_readout #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_val(input int a);
        return 8'((a & 255) ^ ((a >> 8) * 91));
    endfunction

    always @(posedge clk) begin
        if (reset) bus.ram_din <= '0;
        else if (bus.ram_en) bus.ram_din <= ram_val(int'(bus.ram_addr));
    end

    typedef struct packed {
        logic [7:0] data;
        logic       hdr;
    } exp_t;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   len;
        int            mode;
        int            restart_at;
        logic [AW-1:0] rsa;
        logic [AW:0]   rlen;
    } vec_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, pending = 0;
    int beats = 0, dones = 0, busy_cycles = 0;
    int first_beat = -1, last_beat = -1, done_cyc = -1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic h);
        exp_t e;
        e.data = d;
        e.hdr  = h;
        exp_q.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        cyc++;
        if (busy) busy_cycles++;
        if (done) begin
            dones++;
            done_cyc = cyc;
            check("busy_low_at_done", int'(busy), 0);
        end
        if (prev_stall) begin
            check("hold_valid", int'(bus.m_valid), 1);
            check("hold_data", int'(bus.m_data), int'(prev_data));
        end
        if (bus.ram_en) begin
            pending++;
            if (addr_q.size() == 0) check("stray_ram_en", int'(bus.ram_en), 0);
            else check("ram_addr", int'(bus.ram_addr), int'(addr_q.pop_front()));
        end
        if (exp_q.size() == 0) begin
            check("stray_valid", int'(bus.m_valid), 0);
        end else if (bus.m_valid && bus.m_ready) begin
            e = exp_q.pop_front();
            check(e.hdr ? "hdr_beat" : "data_beat", int'(bus.m_data), int'(e.data));
            if (!e.hdr) pending--;
            beats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        if (bus.ram_en) check("pending_le_2", int'(pending <= 2), 1);
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
    endtask

    task automatic tick(input logic st, input logic [AW-1:0] sa, input logic [AW:0] len, input logic rdy);
        @(posedge clk);
        #1;
        start       = st;
        start_addr  = sa;
        length      = len;
        bus.m_ready = rdy;
        #1;
        observe();
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return ((k % 4) == 0) || ((k % 4) == 3);
        endcase
    endfunction

    task automatic load_expect(input logic [AW-1:0] sa, input logic [AW:0] len);
        logic [23:0] l24;
        l24 = 24'(len);
        if (HDR != 0) begin
            push_exp(8'hA5, 1'b1);
            push_exp(l24[7:0], 1'b1);
            push_exp(l24[15:8], 1'b1);
            push_exp(l24[23:16], 1'b1);
        end
        for (int i = 0; i < int'(len); i++) begin
            addr_q.push_back(AW'((int'(sa) + i) % DEPTH));
            push_exp(ram_val((int'(sa) + i) % DEPTH), 1'b0);
        end
        beats = 0; dones = 0; busy_cycles = 0;
        first_beat = -1; last_beat = -1; done_cyc = -1;
    endtask

    task automatic run_readout(input int idx, input vec_t v);
        int c0, k, post, total;
        total = int'(v.len) + HDR;
        load_expect(v.sa, v.len);
        tick(1'b1, v.sa, v.len, ready_for(v.mode, 0));
        c0 = cyc;
        k = 1;
        post = 0;
        while (post < 4 && k < 6000) begin
            if (k == v.restart_at) tick(1'b1, v.rsa, v.rlen, ready_for(v.mode, k));
            else tick(1'b0, AW'($urandom), (AW + 1)'($urandom), ready_for(v.mode, k));
            if (dones != 0) post++;
            k++;
        end
        check("done_count", dones, 1);
        check("beat_count", beats, total);
        check("exp_left", exp_q.size(), 0);
        check("addr_left", addr_q.size(), 0);
        check("busy_cycles", busy_cycles, done_cyc - c0 - 1);
        if (v.mode == 0 && total > 0) begin
            check("first_valid_lat", first_beat - c0, (HDR > 0) ? 1 : 2);
            check("back_to_back", last_beat - first_beat, total - 1);
            check("done_after_last", done_cyc - last_beat, 1);
        end
        if (total == 0) check("zero_len_done", int'(done_cyc > c0 && done_cyc - c0 <= 2), 1);
        $display("readout %0d: sa=%0d len=%0d mode=%0d beats=%0d done_at=+%0d", idx, v.sa, v.len,
                 v.mode, beats, done_cyc - c0);
        exp_q.delete();
        addr_q.delete();
        pending = 0;
    endtask

    vec_t vecs[11];

    initial begin
        vec_t v;
        int k;
        vecs[0]  = '{10'd5,    11'd10,    0, -1,             10'd0,  11'd0};
        vecs[1]  = '{10'd1022, 11'd5,     0, -1,             10'd0,  11'd0};
        vecs[2]  = '{10'd200,  11'd8,     2, -1,             10'd0,  11'd0};
        vecs[3]  = '{10'd300,  11'd8,     1, -1,             10'd0,  11'd0};
        vecs[4]  = '{10'd7,    11'd0,     0, -1,             10'd0,  11'd0};
        vecs[5]  = '{10'd50,   11'd10,    0, 4,              10'd60, 11'd3};
        vecs[6]  = '{10'd50,   11'd10,    0, 12 + HDR_EXTRA, 10'd70, 11'd6};
        vecs[7]  = '{10'd1000, 11'd1,     1, -1,             10'd0,  11'd0};
        vecs[8]  = '{10'd37,   11'd1024,  0, -1,             10'd0,  11'd0};
        vecs[9]  = '{10'h3F0,  11'h123,   2, -1,             10'd0,  11'd0};
        vecs[10] = '{10'd3,    11'd2,     0, -1,             10'd0,  11'd0};

        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ram_en", int'(bus.ram_en), 0);
        check("rst_ram_addr", int'(bus.ram_addr), 0);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_data", int'(bus.m_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) run_readout(i, vecs[i]);

        // Abort a readout after three accepted beats, then check a fresh readout.
        load_expect(10'd100, 11'd10);
        tick(1'b1, 10'd100, 11'd10, 1'b1);
        k = 0;
        while (beats < 3 && k < 50) begin
            tick(1'b0, 10'd0, 11'd0, 1'b1);
            k++;
        end
        check("beats_before_reset", beats, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ram_en", int'(bus.ram_en), 0);
        check("abort_ram_addr", int'(bus.ram_addr), 0);
        check("abort_m_valid", int'(bus.m_valid), 0);
        check("abort_m_data", int'(bus.m_data), 0);
        $display("readout abort: beats=%0d before reset", beats);
        exp_q.delete();
        addr_q.delete();
        pending = 0;
        prev_stall = 1'b0;
        tick(1'b0, 10'd0, 11'd0, 1'b1);
        check("abort_no_done", dones, 0);
        reset = 1'b0;
        v = '{10'd900, 11'd4, 0, -1, 10'd0, 11'd0};
        run_readout(11, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
